// File: rtl/tnn_feature_loader_pkg.sv
// Shared definitions for the TNN feature loaders: default geometry,
// controller state encoding and quantizer rounding/shift constants.
package tnn_feature_loader_pkg;

   localparam int unsigned TNN_NUM_FEAT = 6;
   localparam int unsigned TNN_RAW_W    = 8;
   localparam int unsigned TNN_Q_W      = 3;

   // Quantizer constants for the default geometry.
   localparam int unsigned TNN_Q_SHIFT  = TNN_RAW_W - TNN_Q_W;
   localparam int unsigned TNN_Q_HALF   = 1 << (TNN_Q_SHIFT - 1);

   typedef enum logic [0:0] {
      COLLECT  = 1'b0,
      WAIT_OUT = 1'b1
   } loader_state_e;

   // Right shift that maps a raw value onto the quantized range.
   function automatic int unsigned q_shift(input int unsigned raw_w, input int unsigned q_w);
      return raw_w - q_w;
   endfunction

   // Half an LSB of the quantized value, added before the shift (round-half-up).
   function automatic int unsigned q_half(input int unsigned raw_w, input int unsigned q_w);
      return (raw_w > q_w) ? (1 << (raw_w - q_w - 1)) : 0;
   endfunction

endpackage

// File: rtl/tnn_feature_loader_if.sv
// Handshake bundle between a feature source / vector sink and the loader.
// The master side drives raw beats and vec_ready; the slave side is the loader.
interface tnn_feature_loader_if
   import tnn_feature_loader_pkg::*;
#(
   parameter int unsigned NUM_FEAT = TNN_NUM_FEAT,
   parameter int unsigned RAW_W    = TNN_RAW_W,
   parameter int unsigned Q_W      = TNN_Q_W
) ();

   logic                      feat_valid;
   logic                      feat_ready;
   logic [RAW_W-1:0]          feat_data;
   logic                      feat_last;
   logic                      vec_valid;
   logic                      vec_ready;
   logic [NUM_FEAT*Q_W-1:0]   vec_data;
   logic                      err_frame;
   logic [15:0]               vec_cnt;

   modport master (
      output feat_valid, feat_data, feat_last, vec_ready,
      input  feat_ready, vec_valid, vec_data, err_frame, vec_cnt
   );

   modport slave (
      input  feat_valid, feat_data, feat_last, vec_ready,
      output feat_ready, vec_valid, vec_data, err_frame, vec_cnt
   );

endinterface

// File: rtl/tnn_feat_quant.sv
// Combinational feature quantizer: round-half-up, shift down to Q_W bits,
// saturate at the top code.
module tnn_feat_quant
   import tnn_feature_loader_pkg::*;
#(
   parameter int unsigned RAW_W = TNN_RAW_W,
   parameter int unsigned Q_W   = TNN_Q_W
) (
   input  logic [RAW_W-1:0] i_raw,
   output logic [Q_W-1:0]   o_q
);

   localparam int unsigned SHIFT = q_shift(RAW_W, Q_W);
   localparam int unsigned HALF  = q_half(RAW_W, Q_W);
   localparam int unsigned Q_MAX = (1 << Q_W) - 1;

   // One extra bit keeps the rounding carry out of 0xFF-style inputs.
   logic [RAW_W:0] w_sum;
   logic [RAW_W:0] w_shr;

   // Round, shift and clamp.
   always_comb begin
      w_sum = {1'b0, i_raw} + (RAW_W+1)'(HALF);
      w_shr = w_sum >> SHIFT;
      if (w_shr > (RAW_W+1)'(Q_MAX)) begin
         o_q = '1;
      end else begin
         o_q = w_shr[Q_W-1:0];
      end
   end

endmodule

// File: rtl/tnn_feature_loader.sv
// Collects NUM_FEAT raw feature beats, quantizes each into an assembly
// register and hands the packed vector to the classifier through a
// one-entry registered output stage. Bad framing drops the partial vector.
module tnn_feature_loader
   import tnn_feature_loader_pkg::*;
#(
   parameter int unsigned NUM_FEAT = TNN_NUM_FEAT,
   parameter int unsigned RAW_W    = TNN_RAW_W,
   parameter int unsigned Q_W      = TNN_Q_W
) (
   input  logic                  clk,
   input  logic                  rst,
   tnn_feature_loader_if.slave   bus
);

   localparam int unsigned      IDX_W    = (NUM_FEAT > 1) ? $clog2(NUM_FEAT) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_FEAT - 1);
   localparam int unsigned      VEC_W    = NUM_FEAT * Q_W;

   loader_state_e    r_state;
   loader_state_e    w_state_nxt;
   logic [IDX_W-1:0] r_beat_idx;
   logic [IDX_W-1:0] w_idx_nxt;
   logic [VEC_W-1:0] r_asm;
   logic [VEC_W-1:0] w_asm_nxt;
   logic [VEC_W-1:0] r_vec_data;
   logic             r_vec_valid;
   logic             r_err_frame;
   logic [15:0]      r_vec_cnt;

   logic [Q_W-1:0]   w_q;
   logic             w_feat_ready;
   logic             w_beat;
   logic             w_drain;
   logic             w_at_last;
   logic             w_err;
   logic             w_final;
   logic             w_out_free;
   logic             w_load;

   tnn_feat_quant #(
      .RAW_W (RAW_W),
      .Q_W   (Q_W)
   ) u_quant (
      .i_raw (bus.feat_data),
      .o_q   (w_q)
   );

   assign w_feat_ready = (r_state == COLLECT) && !rst;
   assign w_beat       = bus.feat_valid && w_feat_ready;
   assign w_drain      = r_vec_valid && bus.vec_ready;
   assign w_at_last    = (r_beat_idx == LAST_IDX);
   assign w_err        = w_beat && (bus.feat_last != w_at_last);
   assign w_final      = w_beat && bus.feat_last && w_at_last;
   assign w_out_free   = !r_vec_valid || w_drain;

   assign bus.feat_ready = w_feat_ready;
   assign bus.vec_valid  = r_vec_valid;
   assign bus.vec_data   = r_vec_data;
   assign bus.err_frame  = r_err_frame;
   assign bus.vec_cnt    = r_vec_cnt;

   // Assembly contents including the beat landing this cycle, so the final
   // beat can go straight to the output register without an extra cycle.
   always_comb begin
      w_asm_nxt = r_asm;
      if (w_beat) begin
         w_asm_nxt[r_beat_idx*Q_W +: Q_W] = w_q;
      end
   end

   // Controller next state, beat index and output-load decision.
   always_comb begin
      w_state_nxt = r_state;
      w_idx_nxt   = r_beat_idx;
      w_load      = 1'b0;
      unique case (r_state)
         COLLECT: begin
            if (w_err) begin
               w_idx_nxt = '0;
            end else if (w_final) begin
               w_idx_nxt = '0;
               if (w_out_free) begin
                  w_load = 1'b1;
               end else begin
                  w_state_nxt = WAIT_OUT;
               end
            end else if (w_beat) begin
               w_idx_nxt = r_beat_idx + 1'b1;
            end
         end
         WAIT_OUT: begin
            if (w_drain) begin
               w_load      = 1'b1;
               w_state_nxt = COLLECT;
            end
         end
         default: begin
            w_state_nxt = COLLECT;
            w_idx_nxt   = '0;
         end
      endcase
   end

   // Controller state register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= COLLECT;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Beat index and assembly register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_beat_idx <= '0;
         r_asm      <= '0;
      end else begin
         r_beat_idx <= w_idx_nxt;
         r_asm      <= w_asm_nxt;
      end
   end

   // Output stage: a refill in the drain cycle keeps vec_valid high.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_vec_data  <= '0;
         r_vec_valid <= 1'b0;
      end else if (w_load) begin
         r_vec_data  <= w_asm_nxt;
         r_vec_valid <= 1'b1;
      end else if (w_drain) begin
         r_vec_valid <= 1'b0;
      end
   end

   // Framing-error pulse and delivered-vector counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_err_frame <= 1'b0;
         r_vec_cnt   <= '0;
      end else begin
         r_err_frame <= w_err;
         if (w_drain) begin
            r_vec_cnt <= r_vec_cnt + 16'd1;
         end
      end
   end

endmodule

// File: tb/tb_tnn_feature_loader.sv
// Directed bench for tnn_feature_loader: a table of vectors with
// hand-computed quantized fields, plus hand-written multi-cycle sequences.
module tb_tnn_feature_loader;

   localparam int unsigned NF = 6;
   localparam int unsigned RW = 8;
   localparam int unsigned QW = 3;

   typedef struct {
      logic [RW-1:0] raw [NF];
      logic [QW-1:0] q   [NF];
   } vec_t;

   vec_t tbl [4];

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   tnn_feature_loader_if #(.NUM_FEAT(NF), .RAW_W(RW), .Q_W(QW)) bus ();

   tnn_feature_loader #(.NUM_FEAT(NF), .RAW_W(RW), .Q_W(QW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   logic [RW-1:0] q_in;
   logic [QW-1:0] q_out;

   tnn_feat_quant #(.RAW_W(RW), .Q_W(QW)) u_q (
      .i_raw (q_in),
      .o_q   (q_out)
   );

   int unsigned n_vec  = 0;
   int unsigned n_miss = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_miss++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] pack(input logic [QW-1:0] q [NF]);
      logic [31:0] v = '0;
      for (int k = 0; k < NF; k++) v[k*QW +: QW] = q[k];
      return v;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      bus.feat_valid = 1'b0;
      bus.feat_last  = 1'b0;
      bus.feat_data  = '0;
   endtask

   task automatic beat(input logic [RW-1:0] d, input logic l);
      bus.feat_valid = 1'b1;
      bus.feat_data  = d;
      bus.feat_last  = l;
      step();
   endtask

   task automatic do_reset();
      idle();
      rst = 1'b1;
      #1;
      check("rst_feat_ready_low", {31'd0, bus.feat_ready}, 32'd0);
      step();
      step();
      check("rst_vec_valid", {31'd0, bus.vec_valid}, 32'd0);
      check("rst_vec_data", 32'(bus.vec_data), 32'd0);
      check("rst_err_frame", {31'd0, bus.err_frame}, 32'd0);
      check("rst_vec_cnt", {16'd0, bus.vec_cnt}, 32'd0);
      rst = 1'b0;
      #1;
      check("post_rst_feat_ready", {31'd0, bus.feat_ready}, 32'd1);
   endtask

   // Sends a whole table vector; returns after the edge of the final beat.
   task automatic send_vec(input int unsigned t);
      for (int b = 0; b < NF; b++) beat(tbl[t].raw[b], (b == NF-1));
   endtask

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   initial begin
      tbl[0].raw = '{8'h00, 8'h10, 8'h30, 8'h50, 8'h90, 8'hFF};
      tbl[0].q   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd5, 3'd7};
      tbl[1].raw = '{8'h0F, 8'hEF, 8'hF0, 8'h1F, 8'h20, 8'h80};
      tbl[1].q   = '{3'd0, 3'd7, 3'd7, 3'd1, 3'd1, 3'd4};
      tbl[2].raw = '{8'h2F, 8'h4F, 8'h6F, 8'h8F, 8'hAF, 8'hCF};
      tbl[2].q   = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6};
      tbl[3].raw = '{8'h30, 8'h70, 8'hB0, 8'hD0, 8'hE0, 8'h01};
      tbl[3].q   = '{3'd2, 3'd4, 3'd6, 3'd7, 3'd7, 3'd0};

      idle();
      bus.vec_ready = 1'b1;
      q_in = '0;

      // Quantizer sweep on a standalone instance.
      for (int v = 0; v < 256; v++) begin
         int e;
         q_in = 8'(v);
         #1;
         e = (v + 16) / 32;
         if (e > 7) e = 7;
         check($sformatf("quant_0x%02h", v), {29'd0, q_out}, 32'(e));
      end

      // Back-to-back table vectors with the sink always ready.
      do_reset();
      for (int t = 0; t < 4; t++) begin
         for (int b = 0; b < NF; b++) begin
            beat(tbl[t].raw[b], (b == NF-1));
            if (b == 0 && t > 0) begin
               check($sformatf("b2b_drained_valid_%0d", t), {31'd0, bus.vec_valid}, 32'd0);
               check($sformatf("b2b_cnt_%0d", t), {16'd0, bus.vec_cnt}, 32'(t));
            end
            if (b == 3) check($sformatf("b2b_midvec_valid_%0d", t), {31'd0, bus.vec_valid}, 32'd0);
         end
         check($sformatf("b2b_valid_%0d", t), {31'd0, bus.vec_valid}, 32'd1);
         check($sformatf("b2b_data_%0d", t), 32'(bus.vec_data), pack(tbl[t].q));
         check($sformatf("b2b_err_%0d", t), {31'd0, bus.err_frame}, 32'd0);
      end
      idle();
      step();
      check("b2b_final_cnt", {16'd0, bus.vec_cnt}, 32'd4);
      check("b2b_final_valid", {31'd0, bus.vec_valid}, 32'd0);

      // Backpressure: second vector parks in WAIT_OUT until the first drains.
      do_reset();
      bus.vec_ready = 1'b0;
      send_vec(0);
      check("bp_first_valid", {31'd0, bus.vec_valid}, 32'd1);
      send_vec(1);
      check("bp_wait_feat_ready", {31'd0, bus.feat_ready}, 32'd0);
      check("bp_hold_data", 32'(bus.vec_data), pack(tbl[0].q));
      idle();
      step();
      check("bp_hold_data2", 32'(bus.vec_data), pack(tbl[0].q));
      check("bp_hold_ready2", {31'd0, bus.feat_ready}, 32'd0);
      bus.vec_ready = 1'b1;
      step();
      check("bp_second_valid", {31'd0, bus.vec_valid}, 32'd1);
      check("bp_second_data", 32'(bus.vec_data), pack(tbl[1].q));
      check("bp_back_collect", {31'd0, bus.feat_ready}, 32'd1);
      check("bp_cnt1", {16'd0, bus.vec_cnt}, 32'd1);
      step();
      check("bp_cnt2", {16'd0, bus.vec_cnt}, 32'd2);
      check("bp_empty", {31'd0, bus.vec_valid}, 32'd0);

      // Framing errors: early last, then missing last.
      do_reset();
      beat(8'h10, 1'b0);
      beat(8'h20, 1'b0);
      beat(8'h30, 1'b1);
      check("err_early_pulse", {31'd0, bus.err_frame}, 32'd1);
      check("err_early_novalid", {31'd0, bus.vec_valid}, 32'd0);
      beat(tbl[2].raw[0], 1'b0);
      check("err_early_one_cycle", {31'd0, bus.err_frame}, 32'd0);
      for (int b = 1; b < NF; b++) beat(tbl[2].raw[b], (b == NF-1));
      check("err_early_recover_valid", {31'd0, bus.vec_valid}, 32'd1);
      check("err_early_recover_data", 32'(bus.vec_data), pack(tbl[2].q));
      check("err_early_recover_err", {31'd0, bus.err_frame}, 32'd0);
      for (int b = 0; b < NF; b++) beat(8'hFF, 1'b0);
      check("err_nolast_pulse", {31'd0, bus.err_frame}, 32'd1);
      check("err_nolast_novalid", {31'd0, bus.vec_valid}, 32'd0);
      check("err_nolast_cnt", {16'd0, bus.vec_cnt}, 32'd1);
      send_vec(3);
      check("err_nolast_recover_data", 32'(bus.vec_data), pack(tbl[3].q));
      check("err_nolast_recover_valid", {31'd0, bus.vec_valid}, 32'd1);
      idle();
      step();
      check("err_nolast_err_clear", {31'd0, bus.err_frame}, 32'd0);

      // Reset mid-vector after a delivered vector.
      do_reset();
      send_vec(0);
      idle();
      step();
      check("rmid_cnt_before", {16'd0, bus.vec_cnt}, 32'd1);
      for (int b = 0; b < 4; b++) beat(8'hA0, 1'b0);
      idle();
      rst = 1'b1;
      step();
      check("rmid_err_in_rst", {31'd0, bus.err_frame}, 32'd0);
      rst = 1'b0;
      step();
      check("rmid_valid", {31'd0, bus.vec_valid}, 32'd0);
      check("rmid_cnt", {16'd0, bus.vec_cnt}, 32'd0);
      check("rmid_err", {31'd0, bus.err_frame}, 32'd0);
      send_vec(3);
      check("rmid_next_valid", {31'd0, bus.vec_valid}, 32'd1);
      check("rmid_next_data", 32'(bus.vec_data), pack(tbl[3].q));

      // Reset while parked in WAIT_OUT.
      bus.vec_ready = 1'b0;
      send_vec(1);
      check("rwait_feat_ready", {31'd0, bus.feat_ready}, 32'd0);
      idle();
      rst = 1'b1;
      step();
      rst = 1'b0;
      step();
      check("rwait_valid", {31'd0, bus.vec_valid}, 32'd0);
      check("rwait_feat_ready_back", {31'd0, bus.feat_ready}, 32'd1);
      check("rwait_err", {31'd0, bus.err_frame}, 32'd0);
      bus.vec_ready = 1'b1;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
